// File: rtl/count_day_month.sv
// Calendar day/month stage: BCD day and month registers advanced by the daily carry,
// with manual up/down setting, February sized by leap_year, and the year-carry strobe.
`timescale 1ns / 1ps

module count_day_month #(
  parameter int unsigned DIGIT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_day,
  input  logic               up,
  input  logic               down,
  input  logic               sel_mon,
  input  logic               leap_year,
  output logic [DIGIT_W-1:0] day_unit,
  output logic [DIGIT_W-1:0] day_ten,
  output logic [DIGIT_W-1:0] mon_unit,
  output logic [DIGIT_W-1:0] mon_ten,
  output logic               en_yr
);

  logic [DIGIT_W-1:0] r_day_unit, r_day_ten, r_mon_unit, r_mon_ten;
  logic [5:0]         w_day, w_day_d, w_last, w_new_last;
  logic [3:0]         w_mon, w_mon_d;
  logic               w_manual;

  function automatic logic [5:0] last_day(input logic [3:0] m, input logic leap);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: return 6'd30;
      4'd2:                    return leap ? 6'd29 : 6'd28;
      default:                 return 6'd31;
    endcase
  endfunction

  function automatic logic [3:0] bcd_ten(input logic [5:0] v);
    if (v >= 6'd30)      return 4'd3;
    else if (v >= 6'd20) return 4'd2;
    else if (v >= 6'd10) return 4'd1;
    else                 return 4'd0;
  endfunction

  function automatic logic [3:0] bcd_unit(input logic [5:0] v);
    return 4'(v - 6'(bcd_ten(v)) * 6'd10);
  endfunction

  // Work in binary; the registers stay BCD.
  assign w_day    = 6'(r_day_ten * 10 + r_day_unit);
  assign w_mon    = 4'(r_mon_ten * 10 + r_mon_unit);
  assign w_last   = last_day(w_mon, leap_year);
  assign w_manual = up ^ down;

  always_comb begin
    w_day_d    = w_day;
    w_mon_d    = w_mon;
    w_new_last = w_last;
    if (en_day) begin
      if (w_day < w_last) begin
        w_day_d = w_day + 6'd1;
      end else begin
        w_day_d = 6'd1;
        w_mon_d = (w_mon == 4'd12) ? 4'd1 : w_mon + 4'd1;
      end
    end else if (w_manual) begin
      if (!sel_mon) begin
        if (up) w_day_d = (w_day >= w_last) ? 6'd1 : w_day + 6'd1;
        else    w_day_d = (w_day <= 6'd1) ? w_last : w_day - 6'd1;
      end else begin
        if (up) w_mon_d = (w_mon == 4'd12) ? 4'd1 : w_mon + 4'd1;
        else    w_mon_d = (w_mon == 4'd1) ? 4'd12 : w_mon - 4'd1;
        w_new_last = last_day(w_mon_d, leap_year);
        w_day_d    = (w_day > w_new_last) ? w_new_last : w_day;
      end
    end else if (w_day > w_last) begin
      w_day_d = w_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_day_unit <= DIGIT_W'(1);
      r_day_ten  <= '0;
      r_mon_unit <= DIGIT_W'(1);
      r_mon_ten  <= '0;
    end else begin
      r_day_unit <= DIGIT_W'(bcd_unit(w_day_d));
      r_day_ten  <= DIGIT_W'(bcd_ten(w_day_d));
      r_mon_unit <= DIGIT_W'(bcd_unit(6'(w_mon_d)));
      r_mon_ten  <= DIGIT_W'(bcd_ten(6'(w_mon_d)));
    end
  end

  assign day_unit = r_day_unit;
  assign day_ten  = r_day_ten;
  assign mon_unit = r_mon_unit;
  assign mon_ten  = r_mon_ten;
  // Decoded from current state so the year steps on the same edge the date wraps to 01/01.
  assign en_yr    = rst_n & en_day & (w_day == w_last) & (w_mon == 4'd12);

endmodule

// File: tb/tb_count_day_month.sv
// Directed self-checking bench for count_day_month; dates compared as packed BCD MMDD.
`timescale 1ns / 1ps

module tb_count_day_month;

  logic       clk;
  logic       rst_n;
  logic       en_day, up, down, sel_mon, leap_year;
  logic [3:0] day_unit, day_ten, mon_unit, mon_ten;
  logic       en_yr;
  int         errors;
  int         checks;

  count_day_month #(.DIGIT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_day    (en_day),
    .up        (up),
    .down      (down),
    .sel_mon   (sel_mon),
    .leap_year (leap_year),
    .day_unit  (day_unit),
    .day_ten   (day_ten),
    .mon_unit  (mon_unit),
    .mon_ten   (mon_ten),
    .en_yr     (en_yr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] obs();
    return {mon_ten, mon_unit, day_ten, day_unit};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset to 01/01, then walk to MM/DD with the manual buttons.
  task automatic set_date(input int m, input int d, input logic leap);
    en_day = 0; up = 0; down = 0; sel_mon = 0; leap_year = leap;
    rst_n = 0;
    tick();
    rst_n = 1;
    sel_mon = 1;
    repeat (m - 1) begin up = 1; tick(); end
    sel_mon = 0;
    repeat (d - 1) begin up = 1; tick(); end
    up = 0;
  endtask

  task automatic pulse_day();
    en_day = 1;
    tick();
    en_day = 0;
  endtask

  task automatic test_reset();
    set_date(7, 15, 0);
    checks++;
    if (obs() !== 16'h0715) begin
      errors++; $display("FAIL preload_0715 got %h want 0715", obs());
    end
    rst_n = 0;
    #1;
    checks++;
    if (obs() !== 16'h0101) begin
      errors++; $display("FAIL reset_async got %h want 0101", obs());
    end
    en_day = 1;
    #1;
    checks++;
    if (en_yr !== 1'b0) begin
      errors++; $display("FAIL reset_en_yr got %b want 0", en_yr);
    end
    en_day = 0;
    rst_n = 1;
    tick();
    tick();
    checks++;
    if (obs() !== 16'h0101) begin
      errors++; $display("FAIL reset_hold got %h want 0101", obs());
    end
  endtask

  task automatic test_year_wrap();
    set_date(12, 31, 0);
    en_day = 1;
    #1;
    checks++;
    if (en_yr !== 1'b1) begin
      errors++; $display("FAIL en_yr_at_1231 got %b want 1", en_yr);
    end
    tick();
    en_day = 0;
    #1;
    checks++;
    if (obs() !== 16'h0101) begin
      errors++; $display("FAIL wrap_0101 got %h want 0101", obs());
    end
    checks++;
    if (en_yr !== 1'b0) begin
      errors++; $display("FAIL en_yr_after got %b want 0", en_yr);
    end
    set_date(9, 30, 0);
    en_day = 1;
    #1;
    checks++;
    if (en_yr !== 1'b0) begin
      errors++; $display("FAIL en_yr_0930 got %b want 0", en_yr);
    end
    tick();
    en_day = 0;
    checks++;
    if (obs() !== 16'h1001) begin
      errors++; $display("FAIL month_carry got %h want 1001", obs());
    end
  endtask

  task automatic test_february();
    set_date(2, 28, 1);
    pulse_day();
    checks++;
    if (obs() !== 16'h0229) begin
      errors++; $display("FAIL leap_0229 got %h want 0229", obs());
    end
    pulse_day();
    checks++;
    if (obs() !== 16'h0301) begin
      errors++; $display("FAIL leap_0301 got %h want 0301", obs());
    end
    set_date(2, 28, 0);
    pulse_day();
    checks++;
    if (obs() !== 16'h0301) begin
      errors++; $display("FAIL noleap_0301 got %h want 0301", obs());
    end
  endtask

  task automatic test_manual_month();
    set_date(1, 31, 0);
    sel_mon = 1; up = 1; tick(); up = 0;
    checks++;
    if (obs() !== 16'h0228) begin
      errors++; $display("FAIL mon_up_clamp got %h want 0228", obs());
    end
    down = 1; tick(); down = 0;
    checks++;
    if (obs() !== 16'h0128) begin
      errors++; $display("FAIL mon_down got %h want 0128", obs());
    end
    down = 1; tick(); down = 0;
    checks++;
    if (obs() !== 16'h1228) begin
      errors++; $display("FAIL mon_wrap_down got %h want 1228", obs());
    end
    set_date(3, 31, 1);
    sel_mon = 1; down = 1; tick(); down = 0;
    checks++;
    if (obs() !== 16'h0229) begin
      errors++; $display("FAIL mon_down_clamp_leap got %h want 0229", obs());
    end
    sel_mon = 0;
  endtask

  task automatic test_manual_day();
    set_date(4, 1, 0);
    sel_mon = 0; down = 1; tick(); down = 0;
    checks++;
    if (obs() !== 16'h0430) begin
      errors++; $display("FAIL day_down_wrap got %h want 0430", obs());
    end
    up = 1; tick(); up = 0;
    checks++;
    if (obs() !== 16'h0401) begin
      errors++; $display("FAIL day_up_wrap got %h want 0401", obs());
    end
    up = 1; down = 1;
    repeat (3) tick();
    up = 0; down = 0;
    checks++;
    if (obs() !== 16'h0401) begin
      errors++; $display("FAIL up_down_hold got %h want 0401", obs());
    end
    set_date(4, 10, 0);
    sel_mon = 0; en_day = 1; up = 1;
    tick();
    en_day = 0; up = 0;
    checks++;
    if (obs() !== 16'h0411) begin
      errors++; $display("FAIL en_day_priority got %h want 0411", obs());
    end
  endtask

  task automatic test_leap_drop();
    set_date(2, 29, 1);
    checks++;
    if (obs() !== 16'h0229) begin
      errors++; $display("FAIL preload_0229 got %h want 0229", obs());
    end
    leap_year = 0;
    tick();
    checks++;
    if (obs() !== 16'h0228) begin
      errors++; $display("FAIL leap_drop_clamp got %h want 0228", obs());
    end
  endtask

  task automatic test_back_to_back();
    int yr_count;
    int yr_at;
    yr_count = 0;
    yr_at = 0;
    set_date(1, 1, 0);
    for (int k = 1; k <= 400; k++) begin
      en_day = 1;
      #1;
      if (en_yr === 1'b1) begin
        yr_count++;
        yr_at = k;
      end
      tick();
    end
    en_day = 0;
    checks++;
    if (yr_count !== 1) begin
      errors++; $display("FAIL en_yr_count got %0d want 1", yr_count);
    end
    checks++;
    if (yr_at !== 365) begin
      errors++; $display("FAIL en_yr_position got %0d want 365", yr_at);
    end
    checks++;
    if (obs() !== 16'h0205) begin
      errors++; $display("FAIL after_400_days got %h want 0205", obs());
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 0; en_day = 0; up = 0; down = 0; sel_mon = 0; leap_year = 0;
    tick();
    test_reset();
    test_year_wrap();
    test_february();
    test_manual_month();
    test_manual_day();
    test_leap_drop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
